// File: rtl/mf_peak_detect.sv
// mf_peak_detect: correlation-peak detector for the Re/Im matched-filter outputs.
// Forms |re|+|im|, waits for the first threshold crossing, takes the maximum over
// a fixed window of valid samples, reports it, then blanks for a guard interval.
module mf_peak_detect #(
    parameter int W3    = 32,
    parameter int WIN   = 16,
    parameter int GUARD = 64,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W3-1:0] re_in,
    input  logic [W3-1:0] im_in,
    input  logic          en_in,
    input  logic [W3:0]   thresh,
    output logic          peak_valid,
    output logic [W3:0]   peak_mag,
    output logic [CW-1:0] peak_idx,
    output logic          busy
);

    // Counter widths leave headroom so WIN=1 / GUARD=0 still give legal vectors
    localparam int WCW = $clog2(WIN + 2);
    localparam int GCW = $clog2(GUARD + 2);

    localparam logic [WCW-1:0] WIN_LAST   = WCW'(WIN - 1);
    localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_GUARD  = 2'd2;

    logic [W3-1:0]  a_re;
    logic [W3-1:0]  a_im;
    logic           v1;
    logic [W3:0]    mag;
    logic           mag_v;
    logic [CW-1:0]  idx;
    logic [CW-1:0]  sample_cnt;
    logic [1:0]     state;
    logic [W3:0]    best;
    logic [CW-1:0]  best_idx;
    logic [WCW-1:0] win_cnt;
    logic [GCW-1:0] guard_cnt;
    logic           upd;
    logic [W3:0]    cand_mag;
    logic [CW-1:0]  cand_idx;

    // Stage 1: absolute values; the most negative input maps to 2^(W3-1) unsigned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re <= '0;
            a_im <= '0;
            v1   <= 1'b0;
        end else begin
            a_re <= re_in[W3-1] ? ({W3{1'b0}} - re_in) : re_in;
            a_im <= im_in[W3-1] ? ({W3{1'b0}} - im_in) : im_in;
            v1   <= en_in;
        end
    end

    // Stage 2: one-bit-wider sum and sample index tagging of each valid magnitude
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag        <= '0;
            mag_v      <= 1'b0;
            idx        <= '0;
            sample_cnt <= '0;
        end else begin
            mag   <= {1'b0, a_re} + {1'b0, a_im};
            mag_v <= v1;
            if (v1) begin
                idx        <= sample_cnt;
                sample_cnt <= sample_cnt + CW'(1);
            end
        end
    end

    // Running maximum including the current sample; strict compare keeps the earliest tie
    always_comb begin
        upd      = (mag > best);
        cand_mag = upd ? mag : best;
        cand_idx = upd ? idx : best_idx;
    end

    // Detection FSM advances only on valid magnitudes so en_in gaps stall all counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            best       <= '0;
            best_idx   <= '0;
            win_cnt    <= '0;
            guard_cnt  <= '0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_idx   <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (mag_v) begin
                case (state)
                    S_IDLE: begin
                        if (mag > thresh) begin
                            best     <= mag;
                            best_idx <= idx;
                            win_cnt  <= WCW'(1);
                            if (WIN == 1) begin
                                peak_valid <= 1'b1;
                                peak_mag   <= mag;
                                peak_idx   <= idx;
                                guard_cnt  <= '0;
                                state      <= (GUARD == 0) ? S_IDLE : S_GUARD;
                            end else begin
                                state <= S_SEARCH;
                            end
                        end
                    end
                    S_SEARCH: begin
                        best     <= cand_mag;
                        best_idx <= cand_idx;
                        win_cnt  <= win_cnt + WCW'(1);
                        if (win_cnt == WIN_LAST) begin
                            peak_valid <= 1'b1;
                            peak_mag   <= cand_mag;
                            peak_idx   <= cand_idx;
                            guard_cnt  <= '0;
                            state      <= (GUARD == 0) ? S_IDLE : S_GUARD;
                        end
                    end
                    S_GUARD: begin
                        guard_cnt <= guard_cnt + GCW'(1);
                        if (guard_cnt == GUARD_LAST) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mf_peak_detect.sv
// tb_mf_peak_detect: drives two detector instances (WIN=4/GUARD=8 and WIN=1/GUARD=0)
// with the same sample stream and compares their reports against a window-scan model.
module tb_mf_peak_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] re_in = '0;
    logic [31:0] im_in = '0;
    logic        en_in = 1'b0;
    logic [32:0] thresh = '0;

    logic        pv4, pv1, busy4, busy1;
    logic [32:0] pm4, pm1;
    logic [15:0] pi4, pi1;

    typedef struct {
        logic [32:0] mag;
        logic [15:0] idx;
        int          cyc;
    } rep_t;

    rep_t        obs4[$];
    rep_t        obs1[$];
    rep_t        exp_q[$];
    logic [32:0] smag[$];
    logic [32:0] sth[$];
    int          sdrv[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    mf_peak_detect #(.W3(32), .WIN(4), .GUARD(8), .CW(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .re_in(re_in), .im_in(im_in), .en_in(en_in),
        .thresh(thresh), .peak_valid(pv4), .peak_mag(pm4), .peak_idx(pi4), .busy(busy4)
    );

    mf_peak_detect #(.W3(32), .WIN(1), .GUARD(0), .CW(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .re_in(re_in), .im_in(im_in), .en_in(en_in),
        .thresh(thresh), .peak_valid(pv1), .peak_mag(pm1), .peak_idx(pi1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Rising-edge count used to time each report against its input sample
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every report pulse seen away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv4) obs4.push_back('{mag: pm4, idx: pi4, cyc: cyc});
            if (pv1) obs1.push_back('{mag: pm1, idx: pi1, cyc: cyc});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] magOf(input logic [31:0] re, input logic [31:0] im);
        longint r;
        longint i;
        r = longint'($signed(re));
        i = longint'($signed(im));
        if (r < 0) r = -r;
        if (i < 0) i = -i;
        return 33'(r + i);
    endfunction

    // Scan the valid-sample history: crossing opens a WIN-sample window, the first
    // maximum is reported when the window fills, then GUARD samples are skipped
    function automatic void buildExpected(input int win, input int guard, input int cutoff);
        int i, b, e, n;
        rep_t r;
        exp_q.delete();
        n = smag.size();
        i = 0;
        while (i < n) begin
            if (smag[i] > sth[i]) begin
                e = i + win - 1;
                if (e >= n) break;
                b = i;
                for (int k = i + 1; k <= e; k++)
                    if (smag[k] > smag[b]) b = k;
                r.mag = smag[b];
                r.idx = b[15:0];
                r.cyc = sdrv[e] + 3;
                if (r.cyc <= cutoff) exp_q.push_back(r);
                i = e + 1 + guard;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic checkReports(input string name, input int win, input int guard,
                                input int cutoff, input bit use1);
        rep_t o[$];
        int   n;
        buildExpected(win, guard, cutoff);
        if (use1) o = obs1;
        else      o = obs4;
        checkOutput({name, "_count"}, 64'(o.size()), 64'(exp_q.size()));
        n = (o.size() < exp_q.size()) ? o.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_mag%0d", name, k), 64'(o[k].mag), 64'(exp_q[k].mag));
            checkOutput($sformatf("%s_idx%0d", name, k), 64'(o[k].idx), 64'(exp_q[k].idx));
            checkOutput($sformatf("%s_cyc%0d", name, k), 64'(o[k].cyc), 64'(exp_q[k].cyc));
        end
    endtask

    task automatic applyStimulus(input logic [31:0] re, input logic [31:0] im, input logic en);
        @(negedge clk);
        re_in = re;
        im_in = im;
        en_in = en;
        if (en) begin
            smag.push_back(magOf(re, im));
            sth.push_back(thresh);
            sdrv.push_back(cyc);
        end
    endtask

    task automatic drain();
        repeat (6) applyStimulus(32'd0, 32'd0, 1'b0);
    endtask

    task automatic startSegment();
        smag.delete();
        sth.delete();
        sdrv.delete();
        obs4.delete();
        obs1.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_pv4"}, 64'(pv4), 64'd0);
        checkOutput({tag, "_pm4"}, 64'(pm4), 64'd0);
        checkOutput({tag, "_pi4"}, 64'(pi4), 64'd0);
        checkOutput({tag, "_busy4"}, 64'(busy4), 64'd0);
        checkOutput({tag, "_pv1"}, 64'(pv1), 64'd0);
        checkOutput({tag, "_pm1"}, 64'(pm1), 64'd0);
        checkOutput({tag, "_pi1"}, 64'(pi1), 64'd0);
        checkOutput({tag, "_busy1"}, 64'(busy1), 64'd0);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        en_in = 1'b0;
        #1;
        checkReset(tag);
        repeat (2) @(negedge clk);
        startSegment();
        rst_n = 1'b1;
    endtask

    task automatic checkBoth(input string name);
        checkReports({name, "_w4"}, 4, 8, 1000000000, 1'b0);
        checkReports({name, "_w1"}, 1, 0, 1000000000, 1'b1);
    endtask

    int t1[13] = '{0, 50, 150, 90, 300, 20, 0, 0, 0, 0, 0, 0, 0};
    int t3[10] = '{0, 0, 200, 500, 500, 100, 0, 0, 0, 0};

    initial begin
        int cutoff;
        int v;

        // Basic window: crossing at 150, maximum 300 at index 4
        doReset("rst0");
        thresh = 33'd100;
        foreach (t1[k]) applyStimulus(32'(t1[k]), 32'd0, 1'b1);
        drain();
        checkBoth("t1");
        checkOutput("t1_peak_mag", 64'(pm4), 64'd300);
        checkOutput("t1_peak_idx", 64'(pi4), 64'd4);

        // Most negative inputs on both branches: 33-bit sum with no wrap
        doReset("rst1");
        thresh = 33'd0;
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
        repeat (3) applyStimulus(32'd0, 32'd0, 1'b1);
        drain();
        checkBoth("t2");
        checkOutput("t2_peak_mag1", 64'(pm1), 64'h1_0000_0000);
        checkOutput("t2_peak_mag4", 64'(pm4), 64'h1_0000_0000);

        // Equal maxima: the earlier one wins
        doReset("rst2");
        thresh = 33'd150;
        foreach (t3[k]) applyStimulus(32'(t3[k]), 32'd0, 1'b1);
        drain();
        checkBoth("t3");
        checkOutput("t3_peak_idx", 64'(pi4), 64'd3);

        // Guard blanking: crossing inside guard ignored, later one reported
        doReset("rst3");
        thresh = 33'd100;
        for (int k = 0; k < 20; k++) begin
            v = (k == 0) ? 200 : (k == 6) ? 250 : (k == 15) ? 400 : 0;
            applyStimulus(32'(-v), 32'd0, 1'b1);
        end
        drain();
        checkBoth("t4");
        checkOutput("t4_peak_mag", 64'(pm4), 64'd400);
        checkOutput("t4_peak_idx", 64'(pi4), 64'd15);

        // Gaps with junk data on invalid cycles must not change the result
        doReset("rst4");
        thresh = 33'd100;
        foreach (t1[k]) begin
            applyStimulus(32'(t1[k]), 32'd0, 1'b1);
            applyStimulus($urandom, $urandom, 1'b0);
        end
        drain();
        checkBoth("t5");
        checkOutput("t5_peak_mag", 64'(pm4), 64'd300);
        checkOutput("t5_peak_idx", 64'(pi4), 64'd4);

        // Reset in the middle of a search: no report, index restarts at 0
        doReset("rst5");
        thresh = 33'd100;
        applyStimulus(32'd10, 32'd0, 1'b1);
        applyStimulus(32'd200, 32'd0, 1'b1);
        applyStimulus(32'd50, 32'd0, 1'b1);
        applyStimulus(32'd60, 32'd0, 1'b1);
        repeat (4) applyStimulus(32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("t6_busy", 64'(busy4), 64'd1);
        rst_n = 1'b0;
        cutoff = cyc - 1;
        #1;
        checkReset("t6_rst");
        checkReports("t6a_w4", 4, 8, cutoff, 1'b0);
        checkReports("t6a_w1", 1, 0, cutoff, 1'b1);
        repeat (2) @(negedge clk);
        startSegment();
        rst_n = 1'b1;
        applyStimulus(32'd300, 32'd0, 1'b1);
        repeat (3) applyStimulus(32'd10, 32'd0, 1'b1);
        drain();
        checkBoth("t6b");
        checkOutput("t6b_peak_idx", 64'(pi4), 64'd0);

        // Random streams with random gaps and thresholds
        for (int s = 0; s < 3; s++) begin
            doReset($sformatf("rst_r%0d", s));
            thresh = 33'($urandom_range(100, 300));
            for (int k = 0; k < 150; k++) begin
                applyStimulus(32'($signed($urandom_range(0, 400)) - 200),
                              32'($signed($urandom_range(0, 200)) - 100),
                              ($urandom_range(0, 3) != 0));
            end
            drain();
            checkBoth($sformatf("rnd%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
